// File: rtl/in_port_arbiter_pkg.sv
// Shared types and width helpers for the CPU input-port arbiter.
//   arb_state_t  : arbiter FSM state encoding
//   clog2_min1() : ceil(log2(n)) clamped to at least 1, for index/counter widths
package in_port_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StArb  = 2'd1,
        StAck  = 2'd2
    } arb_state_t;

    // A width of zero is not representable, so degenerate sizes still get one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/in_port_arbiter_if.sv
// Bundle of the CPU read port and the producer-source handshake of the input-port arbiter.
//   cpu_rd_req/ack/data/timeout : CPU read transaction
//   src_valid/src_data/src_ready : per-source valid/ready word transfer
//   grant_id, busy               : status
// Modports:
//   slave  : the arbiter (responds to the CPU, consumes from the sources)
//   master : the environment (CPU plus producer sources)
interface in_port_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 8
);
    localparam int unsigned IdW = in_port_arbiter_pkg::clog2_min1(NUM_REQ);

    logic                        cpu_rd_req;
    logic [DATA_W-1:0]           cpu_rd_data;
    logic                        cpu_rd_ack;
    logic                        cpu_rd_timeout;
    logic [NUM_REQ-1:0]          src_valid;
    logic [NUM_REQ*DATA_W-1:0]   src_data;
    logic [NUM_REQ-1:0]          src_ready;
    logic [IdW-1:0]              grant_id;
    logic                        busy;

    modport slave (
        input  cpu_rd_req,
        input  src_valid,
        input  src_data,
        output cpu_rd_data,
        output cpu_rd_ack,
        output cpu_rd_timeout,
        output src_ready,
        output grant_id,
        output busy
    );

    modport master (
        output cpu_rd_req,
        output src_valid,
        output src_data,
        input  cpu_rd_data,
        input  cpu_rd_ack,
        input  cpu_rd_timeout,
        input  src_ready,
        input  grant_id,
        input  busy
    );

endinterface

// File: rtl/in_port_arbiter_rr_pick.sv
// Combinational rotating-priority picker.
//   req_i : request vector
//   ptr_i : highest-priority index this round (must be < NumReq)
//   any_o : at least one request set
//   idx_o : first set index at or after ptr_i, wrapping modulo NumReq
module in_port_arbiter_rr_pick #(
    parameter int unsigned NumReq = 4,
    parameter int unsigned IdxW   = 2
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [IdxW-1:0]   ptr_i,
    output logic              any_o,
    output logic [IdxW-1:0]   idx_o
);

    // One extra bit so ptr + offset cannot overflow before the modulo fold.
    localparam int unsigned SumW = IdxW + 1;

    logic [SumW-1:0] cand;

    always_comb begin
        any_o = 1'b0;
        idx_o = '0;
        cand  = '0;
        for (int i = 0; i < int'(NumReq); i++) begin
            cand = {1'b0, ptr_i} + SumW'(i);
            if (cand >= SumW'(NumReq)) begin
                cand = cand - SumW'(NumReq);
            end
            if (!any_o && req_i[cand[IdxW-1:0]]) begin
                any_o = 1'b1;
                idx_o = cand[IdxW-1:0];
            end
        end
    end

endmodule

// File: rtl/in_port_arbiter.sv
// Arbitrates the CPU's external input port between NUM_REQ producer sources.
// On a CPU read request one valid source is chosen with rotating priority, its word is
// consumed through valid/ready and returned with a one-cycle registered ack. When no source
// offers a word within TIMEOUT arbitration cycles, DEFAULT_DATA is returned with a timeout flag.
// Ports:
//   clk    : rising-edge clock
//   nReset : asynchronous active-low reset
//   bus    : in_port_arbiter_if.slave (CPU read port, source handshake, grant_id, busy)
module in_port_arbiter
    import in_port_arbiter_pkg::*;
#(
    parameter int unsigned       NUM_REQ      = 4,
    parameter int unsigned       DATA_W       = 8,
    parameter int unsigned       TIMEOUT      = 15,
    parameter logic [DATA_W-1:0] DEFAULT_DATA = '0
) (
    input  logic              clk,
    input  logic              nReset,
    in_port_arbiter_if.slave  bus
);

    localparam int unsigned    IdW        = clog2_min1(NUM_REQ);
    localparam int unsigned    CntW       = clog2_min1(TIMEOUT + 1);
    localparam logic [CntW-1:0] TimeoutCnt = CntW'(TIMEOUT);
    localparam logic [IdW-1:0]  LastIdx    = IdW'(NUM_REQ - 1);

    arb_state_t        state_q, state_d;
    logic [IdW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CntW-1:0]   wait_cnt_q, wait_cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              ack_q, ack_d;
    logic              timeout_q, timeout_d;
    logic [IdW-1:0]    grant_id_q, grant_id_d;

    logic                           pick_any;
    logic [IdW-1:0]                 pick_idx;
    logic [NUM_REQ-1:0]             src_ready;
    logic [NUM_REQ-1:0][DATA_W-1:0] src_words;

    assign src_words = bus.src_data;

    in_port_arbiter_rr_pick #(
        .NumReq (NUM_REQ),
        .IdxW   (IdW)
    ) u_rr_pick (
        .req_i  (bus.src_valid),
        .ptr_i  (rr_ptr_q),
        .any_o  (pick_any),
        .idx_o  (pick_idx)
    );

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        wait_cnt_d = wait_cnt_q;
        data_d     = data_q;
        grant_id_d = grant_id_q;
        ack_d      = 1'b0;
        timeout_d  = 1'b0;
        src_ready  = '0;

        unique case (state_q)
            StIdle: begin
                if (bus.cpu_rd_req) begin
                    state_d    = StArb;
                    wait_cnt_d = '0;
                end
            end
            StArb: begin
                if (!bus.cpu_rd_req) begin
                    // CPU withdrew the request: abandon without touching priority.
                    state_d = StIdle;
                end else if (pick_any) begin
                    src_ready[pick_idx] = 1'b1;
                    data_d              = src_words[pick_idx];
                    grant_id_d          = pick_idx;
                    rr_ptr_d            = (pick_idx == LastIdx) ? '0 : pick_idx + 1'b1;
                    ack_d               = 1'b1;
                    state_d             = StAck;
                end else if (wait_cnt_q == TimeoutCnt) begin
                    data_d    = DEFAULT_DATA;
                    timeout_d = 1'b1;
                    ack_d     = 1'b1;
                    state_d   = StAck;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            StAck: begin
                // Unconditional return to idle keeps a held request from being granted twice.
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q    <= StIdle;
            rr_ptr_q   <= '0;
            wait_cnt_q <= '0;
            data_q     <= '0;
            ack_q      <= 1'b0;
            timeout_q  <= 1'b0;
            grant_id_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            wait_cnt_q <= wait_cnt_d;
            data_q     <= data_d;
            ack_q      <= ack_d;
            timeout_q  <= timeout_d;
            grant_id_q <= grant_id_d;
        end
    end

    assign bus.src_ready      = src_ready;
    assign bus.cpu_rd_data    = data_q;
    assign bus.cpu_rd_ack     = ack_q;
    assign bus.cpu_rd_timeout = timeout_q;
    assign bus.grant_id       = grant_id_q;
    assign bus.busy           = (state_q != StIdle);

endmodule

// File: tb/tb_in_port_arbiter.sv
// Self-checking bench for in_port_arbiter (NUM_REQ=4, DATA_W=8, TIMEOUT=15).
module tb_in_port_arbiter;

    localparam int unsigned NumReq  = 4;
    localparam int unsigned DataW   = 8;
    localparam int unsigned Timeout = 15;

    logic clk    = 1'b0;
    logic nReset = 1'b1;

    always #5 clk = ~clk;

    in_port_arbiter_if #(.NUM_REQ(NumReq), .DATA_W(DataW)) bus ();

    in_port_arbiter #(
        .NUM_REQ      (NumReq),
        .DATA_W       (DataW),
        .TIMEOUT      (Timeout),
        .DEFAULT_DATA (8'h00)
    ) dut (
        .clk    (clk),
        .nReset (nReset),
        .bus    (bus)
    );

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic [1:0]  gid;
        logic [7:0]  exp_data;
        logic        to;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       to;
        logic [1:0] gid;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every ack is matched against the oldest queued expectation.
    always @(negedge clk) begin
        if (nReset && bus.cpu_rd_ack) begin
            exp_t e;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got ack with data %0h expected no ack",
                         bus.cpu_rd_data);
            end else begin
                e = sb_q.pop_front();
                check("ack_data", 32'(bus.cpu_rd_data), 32'(e.data));
                check("ack_timeout", 32'(bus.cpu_rd_timeout), 32'(e.to));
                check("ack_grant_id", 32'(bus.grant_id), 32'(e.gid));
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (bus.busy && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle_busy", 32'(bus.busy), 32'd0);
    endtask

    task automatic do_read(input vec_t v, input string tag);
        int         cyc;
        int         pulses;
        logic       got;
        logic [3:0] exp_ready;
        exp_ready = v.to ? 4'b0000 : (4'b0001 << v.gid);
        wait_idle();
        bus.src_valid  = v.valid;
        bus.src_data   = v.data;
        bus.cpu_rd_req = 1'b1;
        sb_q.push_back('{v.exp_data, v.to, v.gid});
        cyc    = 0;
        pulses = 0;
        got    = 1'b0;
        while (!got && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.src_ready != 4'b0000) begin
                pulses++;
                check({tag, "_ready"}, 32'(bus.src_ready), 32'(exp_ready));
            end
            if (bus.cpu_rd_ack) got = 1'b1;
        end
        bus.cpu_rd_req = 1'b0;
        check({tag, "_latency"}, 32'(cyc), v.to ? 32'(2 + Timeout) : 32'd2);
        check({tag, "_ready_pulses"}, 32'(pulses), v.to ? 32'd0 : 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        int acks;
        vec_t v;

        // Expected winners follow from rr_ptr starting at 0 after reset.
        vecs[0]  = '{4'b0100, 32'hAA55CC33, 2'd2, 8'h55, 1'b0};
        vecs[1]  = '{4'b1000, 32'hA3000077, 2'd3, 8'hA3, 1'b0};
        vecs[2]  = '{4'b1111, 32'h44332211, 2'd0, 8'h11, 1'b0};
        vecs[3]  = '{4'b1111, 32'h44332211, 2'd1, 8'h22, 1'b0};
        vecs[4]  = '{4'b1111, 32'h44332211, 2'd2, 8'h33, 1'b0};
        vecs[5]  = '{4'b1111, 32'h44332211, 2'd3, 8'h44, 1'b0};
        vecs[6]  = '{4'b1111, 32'h44332211, 2'd0, 8'h11, 1'b0};
        vecs[7]  = '{4'b0101, 32'h99C28866, 2'd2, 8'hC2, 1'b0};
        vecs[8]  = '{4'b0011, 32'h5A4B3C2D, 2'd0, 8'h2D, 1'b0};
        vecs[9]  = '{4'b0000, 32'hFFFFFFFF, 2'd0, 8'h00, 1'b1};
        vecs[10] = '{4'b0011, 32'h5A4B3C2D, 2'd1, 8'h3C, 1'b0};
        vecs[11] = '{4'b1001, 32'hE100000F, 2'd3, 8'hE1, 1'b0};

        bus.cpu_rd_req = 1'b0;
        bus.src_valid  = '0;
        bus.src_data   = '0;

        #2 nReset = 1'b0;
        #20;
        check("rst_ack", 32'(bus.cpu_rd_ack), 32'd0);
        check("rst_data", 32'(bus.cpu_rd_data), 32'd0);
        check("rst_timeout", 32'(bus.cpu_rd_timeout), 32'd0);
        check("rst_grant_id", 32'(bus.grant_id), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_ready", 32'(bus.src_ready), 32'd0);
        @(negedge clk);
        nReset = 1'b1;

        for (int i = 0; i < 12; i++) begin
            do_read(vecs[i], $sformatf("vec%0d", i));
        end
        // rr_ptr is now 0, last grant 3.

        // Abort: request withdrawn one cycle into arbitration.
        wait_idle();
        bus.src_valid  = 4'b0000;
        bus.cpu_rd_req = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy_arb", 32'(bus.busy), 32'd1);
        check("abort_ready_arb", 32'(bus.src_ready), 32'd0);
        @(negedge clk);
        bus.cpu_rd_req = 1'b0;
        @(posedge clk);
        #1;
        check("abort_busy_idle", 32'(bus.busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("abort_no_ack", 32'(bus.cpu_rd_ack), 32'd0);
        end

        // Full-length timeout after an abort shows wait_cnt restarts; rr_ptr stays 0.
        v = '{4'b0000, 32'h12345678, 2'd3, 8'h00, 1'b1};
        do_read(v, "abort_to");
        v = '{4'b1111, 32'h44332211, 2'd0, 8'h11, 1'b0};
        do_read(v, "after_to");

        // Request held high across three acks: one grant per pass (grants 1,2,3).
        wait_idle();
        bus.src_valid = 4'b1111;
        bus.src_data  = 32'h44332211;
        sb_q.push_back('{8'h22, 1'b0, 2'd1});
        sb_q.push_back('{8'h33, 1'b0, 2'd2});
        sb_q.push_back('{8'h44, 1'b0, 2'd3});
        bus.cpu_rd_req = 1'b1;
        pulses = 0;
        acks   = 0;
        for (int i = 0; i < 11; i++) begin
            @(posedge clk);
            #1;
            if (bus.src_ready != 4'b0000) pulses++;
            if (bus.cpu_rd_ack) acks++;
            if (i == 7) bus.cpu_rd_req = 1'b0;
        end
        check("held_ready_pulses", 32'(pulses), 32'd3);
        check("held_acks", 32'(acks), 32'd3);
        check("held_busy_end", 32'(bus.busy), 32'd0);

        // Move rr_ptr to 2 so the reset test can see it cleared.
        v = '{4'b0010, 32'h44332211, 2'd1, 8'h22, 1'b0};
        do_read(v, "pre_rst");

        // Asynchronous reset in the middle of a grant cycle.
        wait_idle();
        bus.src_valid  = 4'b0001;
        bus.src_data   = 32'h000000E7;
        bus.cpu_rd_req = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_ready_before", 32'(bus.src_ready), 32'h1);
        #2 nReset = 1'b0;
        #1;
        check("midrst_ready", 32'(bus.src_ready), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_data", 32'(bus.cpu_rd_data), 32'd0);
        check("midrst_grant_id", 32'(bus.grant_id), 32'd0);
        bus.cpu_rd_req = 1'b0;
        @(negedge clk);
        nReset = 1'b1;
        @(posedge clk);
        #1;
        check("postrst_ack", 32'(bus.cpu_rd_ack), 32'd0);
        check("postrst_timeout", 32'(bus.cpu_rd_timeout), 32'd0);
        check("postrst_data", 32'(bus.cpu_rd_data), 32'd0);
        check("postrst_grant_id", 32'(bus.grant_id), 32'd0);
        check("postrst_busy", 32'(bus.busy), 32'd0);
        check("postrst_ready", 32'(bus.src_ready), 32'd0);

        // rr_ptr must be back at 0.
        v = '{4'b1111, 32'h44332211, 2'd0, 8'h11, 1'b0};
        do_read(v, "postrst_read");

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
